fetch_stage_ctrl: RTL and testbench
===================================

// Module: fetch_stage_ctrl
// PURPOSE
//   Fetch stage of the 5-stage MIPS pipeline. Owns the PC and the IF/ID register, and acts on the
//   stall/flush lines from the hazard unit and the branch resolution from ID.
//   Detects the HALT instruction and drains the pipeline. Raises o_halted for the debug unit.
//   Counts hazard stall cycles for debug readout.
// PARAMETERS
//   ADDR_SZ       32          PC / instruction-memory address width
//   INST_SZ       32          instruction width
//   HALT_OPCODE   6'b111111   opcode field instr[31:26] that marks HALT
//   DRAIN_CYCLES  4           advancing cycles after HALT leaves IF/ID before o_halted rises
//   STALL_CNT_SZ  16          width of the stall-cycle counter
// PORTS
//   i_clk              in   1          clock, all state on rising edge
//   i_reset            in   1          synchronous, active-high reset
//   i_enable           in   1          debug step/run enable; 0 = freeze all state
//   i_stall_pc_HD      in   1          hold PC (hazard unit)
//   i_stall_if_id_HD   in   1          hold IF/ID (hazard unit)
//   i_pc_src_D         in   1          branch/jump resolved taken in ID
//   i_target_D         in   ADDR_SZ    taken target address from ID
//   i_imem_data        in   INST_SZ    instruction memory read data (combinational read of o_imem_addr)
//   o_imem_addr        out  ADDR_SZ    current PC
//   o_pc4_D            out  ADDR_SZ    IF/ID: PC+4 of the held instruction
//   o_instr_D          out  INST_SZ    IF/ID: instruction (0 = NOP when flushed/invalid)
//   o_valid_D          out  1          IF/ID holds a real instruction
//   o_halted           out  1          pipeline drained after HALT
//   o_stall_count      out  STALL_CNT_SZ  saturating count of stalled cycles
// BEHAVIOUR
//   Reset (one edge, any state): PC=0, o_pc4_D=0, o_instr_D=0, o_valid_D=0, o_halted=0,
//     o_stall_count=0, state=RUN, drain counter=0. A reset while HALTED restarts at PC 0.
//   Priority per edge: i_reset > !i_enable (nothing changes) > stall > pc_src > sequential.
//   PC update (RUN only, enabled): i_stall_pc_HD -> hold; else i_pc_src_D -> i_target_D;
//     else PC+4, wrapping modulo 2^ADDR_SZ. PC is frozen in DRAIN and HALTED.
//   IF/ID update (enabled): i_stall_if_id_HD -> hold all fields.
//     Else, if i_pc_src_D in RUN -> flush: instr=0, valid=0, pc4=0.
//     Else, in RUN -> load {PC+4, i_imem_data, valid=1}.
//     Else, in DRAIN/HALTED -> load NOP: instr=0, valid=0.
//   The two stall lines are honoured independently. If the PC is held while IF/ID loads, the
//     same instruction enters IF/ID twice; the hazard unit never does this.
//   Stall beats pc_src: a stalled branch is not yet resolved, so pc_src is ignored that edge.
//   FSM RUN -> DRAIN: enabled edge in RUN where i_imem_data[31:26]==HALT_OPCODE is
//     loaded into IF/ID (no stall, no pc_src).
//     A HALT fetched in the same cycle as pc_src is wrong-path: squashed, FSM stays RUN.
//     A HALT held by a stall re-evaluates on the next edge.
//   DRAIN: i_pc_src_D and the flush are ignored, because no older branch can remain in ID.
//     The drain counter increments on each enabled edge with no IF/ID stall.
//     At DRAIN_CYCLES -> HALTED, and o_halted=1 from that edge on.
//   HALTED: terminal until reset. IF/ID holds NOP, PC frozen, o_halted stays 1.
//   Stall counter: +1 on each enabled edge with i_stall_pc_HD=1 and state != HALTED.
//     Saturates at all-ones, no wrap.
//   Latency: the instruction at PC appears on o_instr_D one enabled edge later.
// STRUCTURE
//   fetch_pkg: state encoding (RUN/DRAIN/HALTED), NOP_INSTR=0, PC_INCR=4, HALT opcode field slice.
//   Sub-module pc_register: PC flop with hold/load/increment and sync reset.
//   FSM, IF/ID register and stall counter stay in this module.
// TESTING
//   1. Reset, enable=1, memory at 0,4,8 -> o_imem_addr 0,4,8; o_instr_D trails by 1; o_pc4_D=4,8.
//   2. stall_pc & stall_if_id held 2 cycles at PC=8 -> PC and IF/ID unchanged, o_stall_count=2.
//   3. pc_src=1, target=0x40 at PC=0x10 -> next PC=0x40, o_instr_D=0, o_valid_D=0.
//      Stall + pc_src together -> hold only.
//   4. HALT at 0x20 -> PC frozen at 0x20; o_halted=1 exactly 4 enabled edges after HALT leaves IF/ID.
//      A stall during DRAIN extends this by 1.
//   5. HALT fetched while pc_src=1 -> squashed, state RUN, PC=target.
//      enable=0 for 3 cycles mid-run -> all outputs frozen.
//   6. PC=0xFFFFFFFC sequential -> wraps to 0. Force 70000 stalls -> o_stall_count=0xFFFF.
//      Reset while HALTED -> outputs return to reset values.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch stage: FSM encoding, NOP/increment constants
// and the opcode field location used for HALT detection.
package fetch_pkg;

  localparam int unsigned ADDR_SZ_DEF      = 32;
  localparam int unsigned INST_SZ_DEF      = 32;
  localparam int unsigned OPCODE_SZ        = 6;
  localparam int unsigned DRAIN_CYCLES_DEF = 4;
  localparam int unsigned STALL_CNT_SZ_DEF = 16;
  localparam int unsigned PC_INCR          = 4;

  localparam logic [OPCODE_SZ-1:0] HALT_OPCODE_DEF = 6'b111111;
  localparam logic [31:0]          NOP_INSTR       = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_stage_ctrl_if.sv
// Fetch-stage bus: hazard/branch controls and imem read in, IF/ID register out.
interface fetch_stage_ctrl_if #(
  parameter int unsigned ADDR_SZ = 32,
  parameter int unsigned INST_SZ = 32
);

  logic               i_stall_pc_HD;
  logic               i_stall_if_id_HD;
  logic               i_pc_src_D;
  logic [ADDR_SZ-1:0] i_target_D;
  logic [INST_SZ-1:0] i_imem_data;
  logic [ADDR_SZ-1:0] o_imem_addr;
  logic [ADDR_SZ-1:0] o_pc4_D;
  logic [INST_SZ-1:0] o_instr_D;
  logic               o_valid_D;

  modport master (
    input  i_stall_pc_HD, i_stall_if_id_HD, i_pc_src_D, i_target_D, i_imem_data,
    output o_imem_addr, o_pc4_D, o_instr_D, o_valid_D
  );

  modport slave (
    output i_stall_pc_HD, i_stall_if_id_HD, i_pc_src_D, i_target_D, i_imem_data,
    input  o_imem_addr, o_pc4_D, o_instr_D, o_valid_D
  );

endinterface

// File: rtl/fetch_stage_ctrl_pc_register.sv
// Program counter: hold, load a branch target, or step to the next word.
module fetch_stage_ctrl_pc_register
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_SZ = ADDR_SZ_DEF
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_hold,
  input  logic               i_load,
  input  logic [ADDR_SZ-1:0] i_target,
  output logic [ADDR_SZ-1:0] o_pc
);

  // Increment wraps naturally modulo 2^ADDR_SZ
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_pc <= '0;
    end else if (!i_hold) begin
      o_pc <= i_load ? i_target : o_pc + ADDR_SZ'(PC_INCR);
    end
  end

endmodule

// File: rtl/fetch_stage_ctrl.sv
// Fetch stage: PC, IF/ID register, HALT drain FSM and hazard stall counter.
module fetch_stage_ctrl
  import fetch_pkg::*;
#(
  parameter int unsigned           ADDR_SZ      = ADDR_SZ_DEF,
  parameter int unsigned           INST_SZ      = INST_SZ_DEF,
  parameter logic [OPCODE_SZ-1:0]  HALT_OPCODE  = HALT_OPCODE_DEF,
  parameter int unsigned           DRAIN_CYCLES = DRAIN_CYCLES_DEF,
  parameter int unsigned           STALL_CNT_SZ = STALL_CNT_SZ_DEF
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_enable,
  fetch_stage_ctrl_if.master      bus,
  output logic                    o_halted,
  output logic [STALL_CNT_SZ-1:0] o_stall_count
);

  localparam int unsigned DRAIN_W = $clog2(DRAIN_CYCLES + 1);

  fetch_state_e       state, state_nx;
  logic [DRAIN_W-1:0] drain_cnt, drain_cnt_nx;
  logic [ADDR_SZ-1:0] pc4_nx;
  logic [INST_SZ-1:0] instr_nx;
  logic               valid_nx;
  logic               halted_nx;
  logic [STALL_CNT_SZ-1:0] stall_cnt_nx;

  logic [ADDR_SZ-1:0] pc_plus4;
  logic               halt_fetch;
  logic               enter_drain;
  logic               pc_hold;

  assign pc_plus4   = bus.o_imem_addr + ADDR_SZ'(PC_INCR);
  assign halt_fetch = (bus.i_imem_data[INST_SZ-1 -: OPCODE_SZ] == HALT_OPCODE);

  // HALT accepted into IF/ID: the PC parks on the HALT address from this edge on
  assign enter_drain = i_enable && (state == ST_RUN) && !bus.i_stall_if_id_HD
                    && !bus.i_pc_src_D && halt_fetch;
  assign pc_hold = !i_enable || (state != ST_RUN) || bus.i_stall_pc_HD || enter_drain;

  fetch_stage_ctrl_pc_register #(
    .ADDR_SZ (ADDR_SZ)
  ) u_pc_register (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_hold   (pc_hold),
    .i_load   (bus.i_pc_src_D),
    .i_target (bus.i_target_D),
    .o_pc     (bus.o_imem_addr)
  );

  // Next-state, IF/ID and counter update
  always_comb begin
    state_nx     = state;
    drain_cnt_nx = drain_cnt;
    pc4_nx       = bus.o_pc4_D;
    instr_nx     = bus.o_instr_D;
    valid_nx     = bus.o_valid_D;
    halted_nx    = o_halted;
    stall_cnt_nx = o_stall_count;

    if (i_enable) begin
      if (bus.i_stall_pc_HD && (state != ST_HALTED) && (o_stall_count != '1)) begin
        stall_cnt_nx = o_stall_count + STALL_CNT_SZ'(1);
      end

      if (!bus.i_stall_if_id_HD) begin
        case (state)
          ST_RUN: begin
            if (bus.i_pc_src_D) begin
              pc4_nx   = '0;
              instr_nx = INST_SZ'(NOP_INSTR);
              valid_nx = 1'b0;
            end else begin
              pc4_nx   = pc_plus4;
              instr_nx = bus.i_imem_data;
              valid_nx = 1'b1;
              if (halt_fetch) begin
                state_nx     = ST_DRAIN;
                drain_cnt_nx = '0;
              end
            end
          end
          ST_DRAIN: begin
            instr_nx     = INST_SZ'(NOP_INSTR);
            valid_nx     = 1'b0;
            drain_cnt_nx = drain_cnt + DRAIN_W'(1);
            if (drain_cnt_nx == DRAIN_W'(DRAIN_CYCLES)) begin
              state_nx  = ST_HALTED;
              halted_nx = 1'b1;
            end
          end
          ST_HALTED: begin
            instr_nx = INST_SZ'(NOP_INSTR);
            valid_nx = 1'b0;
          end
          default: begin
            state_nx = ST_RUN;
          end
        endcase
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state         <= ST_RUN;
      drain_cnt     <= '0;
      bus.o_pc4_D   <= '0;
      bus.o_instr_D <= '0;
      bus.o_valid_D <= 1'b0;
      o_halted      <= 1'b0;
      o_stall_count <= '0;
    end else begin
      state         <= state_nx;
      drain_cnt     <= drain_cnt_nx;
      bus.o_pc4_D   <= pc4_nx;
      bus.o_instr_D <= instr_nx;
      bus.o_valid_D <= valid_nx;
      o_halted      <= halted_nx;
      o_stall_count <= stall_cnt_nx;
    end
  end

endmodule

// File: tb/tb_fetch_stage_ctrl.sv
// Directed bench for fetch_stage_ctrl: sequencing, stalls, flush, HALT drain,
// enable freeze, PC wrap and stall-counter saturation.
module tb_fetch_stage_ctrl;

  logic        clk;
  logic        reset;
  logic        enable;
  logic        halted;
  logic [15:0] stall_count;

  logic        halt_en;
  logic [31:0] halt_addr;

  int unsigned total;
  int unsigned bad;

  fetch_stage_ctrl_if #(.ADDR_SZ(32), .INST_SZ(32)) bus ();

  fetch_stage_ctrl dut (
    .i_clk         (clk),
    .i_reset       (reset),
    .i_enable      (enable),
    .bus           (bus),
    .o_halted      (halted),
    .o_stall_count (stall_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] exp_instr(input logic [31:0] addr);
    return {6'd1, addr[25:0]};
  endfunction

  // Instruction memory model: opcode 1 everywhere, optional HALT at halt_addr
  always_comb begin
    if (halt_en && (bus.o_imem_addr == halt_addr)) bus.i_imem_data = {6'b111111, 26'd0};
    else                                           bus.i_imem_data = exp_instr(bus.o_imem_addr);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ifid(input string tag, input logic [31:0] addr, input logic [31:0] instr,
                          input logic [31:0] pc4, input logic valid);
    chk({tag, ".addr"},  64'(bus.o_imem_addr), 64'(addr));
    chk({tag, ".instr"}, 64'(bus.o_instr_D),   64'(instr));
    chk({tag, ".pc4"},   64'(bus.o_pc4_D),     64'(pc4));
    chk({tag, ".valid"}, 64'(bus.o_valid_D),   64'(valid));
  endtask

  initial begin
    clk = 1'b0;
    total = 0;
    bad = 0;
    reset = 1'b1;
    enable = 1'b1;
    halt_en = 1'b0;
    halt_addr = 32'h20;
    bus.i_stall_pc_HD = 1'b0;
    bus.i_stall_if_id_HD = 1'b0;
    bus.i_pc_src_D = 1'b0;
    bus.i_target_D = '0;

    // Reset state
    tick();
    reset = 1'b0;
    chk_ifid("rst", 32'h0, 32'h0, 32'h0, 1'b0);
    chk("rst.halted", 64'(halted), 64'd0);
    chk("rst.stall", 64'(stall_count), 64'd0);

    // Sequential fetch, IF/ID trails PC by one edge
    tick();
    chk_ifid("seq1", 32'h4, exp_instr(32'h0), 32'h4, 1'b1);
    tick();
    chk_ifid("seq2", 32'h8, exp_instr(32'h4), 32'h8, 1'b1);

    // Two-cycle stall at PC=8
    bus.i_stall_pc_HD = 1'b1;
    bus.i_stall_if_id_HD = 1'b1;
    tick();
    tick();
    chk_ifid("stall", 32'h8, exp_instr(32'h4), 32'h8, 1'b1);
    chk("stall.cnt", 64'(stall_count), 64'd2);
    bus.i_stall_pc_HD = 1'b0;
    bus.i_stall_if_id_HD = 1'b0;
    tick();
    chk_ifid("post_stall", 32'hC, exp_instr(32'h8), 32'hC, 1'b1);
    tick();
    chk("at10.addr", 64'(bus.o_imem_addr), 64'h10);

    // Stall together with pc_src: hold only
    bus.i_stall_pc_HD = 1'b1;
    bus.i_stall_if_id_HD = 1'b1;
    bus.i_pc_src_D = 1'b1;
    bus.i_target_D = 32'h40;
    tick();
    chk_ifid("stall_br", 32'h10, exp_instr(32'hC), 32'h10, 1'b1);
    chk("stall_br.cnt", 64'(stall_count), 64'd3);

    // Taken branch flushes IF/ID
    bus.i_stall_pc_HD = 1'b0;
    bus.i_stall_if_id_HD = 1'b0;
    tick();
    chk_ifid("branch", 32'h40, 32'h0, 32'h0, 1'b0);
    bus.i_pc_src_D = 1'b0;
    tick();
    chk_ifid("tgt", 32'h44, exp_instr(32'h40), 32'h44, 1'b1);

    // Wrong-path HALT at 0x44 squashed by a taken branch
    halt_en = 1'b1;
    halt_addr = 32'h44;
    bus.i_pc_src_D = 1'b1;
    bus.i_target_D = 32'h18;
    tick();
    chk_ifid("squash", 32'h18, 32'h0, 32'h0, 1'b0);
    bus.i_pc_src_D = 1'b0;
    halt_addr = 32'h20;
    tick();
    chk_ifid("squash_run", 32'h1C, exp_instr(32'h18), 32'h1C, 1'b1);
    tick();
    chk("pre_halt.addr", 64'(bus.o_imem_addr), 64'h20);

    // HALT at 0x20 enters IF/ID, then drains with one stalled edge inside
    tick();
    chk_ifid("halt_id", 32'h20, {6'b111111, 26'd0}, 32'h24, 1'b1);
    chk("halt_id.halted", 64'(halted), 64'd0);
    tick();
    chk("drain1.instr", 64'(bus.o_instr_D), 64'h0);
    chk("drain1.valid", 64'(bus.o_valid_D), 64'd0);
    bus.i_stall_if_id_HD = 1'b1;
    tick();
    bus.i_stall_if_id_HD = 1'b0;
    tick();
    tick();
    chk("drain4.halted", 64'(halted), 64'd0);
    chk("drain4.addr", 64'(bus.o_imem_addr), 64'h20);
    tick();
    chk("drain5.halted", 64'(halted), 64'd1);

    // HALTED is terminal and does not count stalls
    bus.i_stall_pc_HD = 1'b1;
    bus.i_pc_src_D = 1'b1;
    tick();
    bus.i_stall_pc_HD = 1'b0;
    bus.i_pc_src_D = 1'b0;
    tick();
    chk_ifid("halted", 32'h20, 32'h0, 32'h24, 1'b0);
    chk("halted.halted", 64'(halted), 64'd1);
    chk("halted.cnt", 64'(stall_count), 64'd3);

    // Reset while HALTED
    reset = 1'b1;
    tick();
    reset = 1'b0;
    halt_en = 1'b0;
    chk_ifid("rst2", 32'h0, 32'h0, 32'h0, 1'b0);
    chk("rst2.halted", 64'(halted), 64'd0);
    chk("rst2.cnt", 64'(stall_count), 64'd0);

    // Enable low freezes everything, including the stall counter
    tick();
    chk_ifid("run", 32'h4, exp_instr(32'h0), 32'h4, 1'b1);
    enable = 1'b0;
    bus.i_stall_pc_HD = 1'b1;
    bus.i_pc_src_D = 1'b1;
    bus.i_target_D = 32'h80;
    repeat (3) tick();
    chk_ifid("frozen", 32'h4, exp_instr(32'h0), 32'h4, 1'b1);
    chk("frozen.cnt", 64'(stall_count), 64'd0);
    enable = 1'b1;
    bus.i_stall_pc_HD = 1'b0;
    bus.i_pc_src_D = 1'b0;
    tick();
    chk_ifid("thaw", 32'h8, exp_instr(32'h4), 32'h8, 1'b1);

    // PC wrap at the top of the address space
    bus.i_pc_src_D = 1'b1;
    bus.i_target_D = 32'hFFFF_FFFC;
    tick();
    chk("top.addr", 64'(bus.o_imem_addr), 64'hFFFF_FFFC);
    bus.i_pc_src_D = 1'b0;
    tick();
    chk_ifid("wrap", 32'h0, exp_instr(32'hFFFF_FFFC), 32'h0, 1'b1);

    // Stall counter saturates
    bus.i_stall_pc_HD = 1'b1;
    bus.i_stall_if_id_HD = 1'b1;
    repeat (70000) @(posedge clk);
    #1;
    chk("sat.cnt", 64'(stall_count), 64'hFFFF);
    chk("sat.addr", 64'(bus.o_imem_addr), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
